verifier_mle_fold: RTL and testbench
====================================

VERIFIER_MLE_FOLD -- requirements
Module: verifier_mle_fold

Interface
REQ-001 Parameter nValBits, default 6: number of variables; the table holds nValues = 2^nValBits field elements.
REQ-002 Parameter nParBits, default 2: the fold datapath has nParallel = 2^nParBits lanes; nParBits SHALL be less than nValBits.
REQ-003 Parameter nEarlyBits, default 4: variable count used in early mode; nEarlyBits SHALL be at least 1 and at most nValBits.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rstb  in  1  reset; synchronous and active-low.
REQ-006 en  in  1  start request; sampled only in IDLE.
REQ-007 early  in  1  sampled with en; 1 selects the nEarlyBits-variable fold over vals_in[0..2^nEarlyBits-1].
REQ-008 tau  in  nValBits x `F_NBITS  evaluation point; tau[b] binds table-index bit b.
REQ-009 vals_in  in  nValues x `F_NBITS  table values, canonical mod `F_Q unless REQ-027 applies.
REQ-010 value_out  out  `F_NBITS  multilinear-extension evaluation, sum over i of chi_i(tau)*vals_in[i] mod `F_Q.
REQ-011 ready  out  1  high when idle or done; low while busy.

Function
REQ-012 States: IDLE, FOLD, DONE; DONE behaves as IDLE for handshake purposes (ready=1, en accepted).
REQ-013 In IDLE/DONE, en=1 latches tau, early and the active vals_in into an internal buffer, deasserts ready next cycle and enters FOLD with round r=0; the inputs SHALL NOT be sampled again until the fold finishes.
REQ-014 Let m = nEarlyBits when early=1, else nValBits. Round r (0..m-1) computes w'[k] = w[2k] + tau[r]*(w[2k+1] - w[2k]) mod `F_Q for k = 0 .. 2^(m-r-1)-1, in place.
REQ-015 Each cycle in FOLD processes min(nParallel, pairs remaining in round) pairs in ascending k order; a round never shares a cycle with the next round.
REQ-016 Subtraction wraps: (a - b) mod `F_Q computed as a + `F_Q - b with a conditional subtract; products are reduced fully mod `F_Q before accumulation; all stored words stay in [0, `F_Q).
REQ-017 FOLD cycle count = sum over r of ceil(2^(m-r-1)/nParallel); with the defaults this is 17 for early=0 and 5 for early=1.
REQ-018 After the final round, the cycle that writes w[0] moves to DONE; value_out = w[0] and ready = 1 on the following posedge, so ready rises exactly FOLD-count + 1 cycles after the en-sampling edge.
REQ-019 value_out holds its value until the next completion; it does not change during a subsequent FOLD.
REQ-020 en asserted while in FOLD SHALL be ignored and SHALL NOT be queued.
REQ-021 en held high continuously restarts a fold on each cycle in which ready=1, using the inputs present on that cycle.
REQ-022 tau[b] for b >= m SHALL NOT affect the result; vals_in[i] for i >= 2^m SHALL NOT affect the result.

Reset
REQ-023 rstb=0 at a posedge forces IDLE, ready=1, value_out=0, round counter 0.
REQ-024 Reset asserted mid-FOLD abandons the computation; no partial value SHALL reach value_out.
REQ-025 The first en after reset release is accepted on the cycle it is sampled.
REQ-026 The internal table buffer need not be cleared by reset.

Configuration
REQ-027 VERIFIER_MLE_FOLD_REDUCE_EN defined: tau and vals_in words are reduced mod `F_Q as they are latched, so any `F_NBITS-bit input is legal.
REQ-028 VERIFIER_MLE_FOLD_REDUCE_EN undefined: inputs are latched unreduced, and non-canonical inputs give an undefined value_out; latency and all other behaviour are identical in both builds.

Verification
REQ-029 All vals_in=5, random tau, early=0 -> value_out=5, ready rises 18 cycles after the en edge.
REQ-030 tau all 0 -> value_out=vals_in[0]; tau all 1 -> value_out=vals_in[63]; tau[0]=1 with the rest 0 -> value_out=vals_in[1].
REQ-031 early=1, tau all 1, random vals_in -> value_out=vals_in[15], ready rises 6 cycles after en; changing vals_in[16..63] or tau[4..5] leaves the result unchanged.
REQ-032 Eight back-to-back random runs (seed 3) alternating early=0/1, each started on the ready rising edge -> value_out equals the software dot product of the chi table with vals_in mod `F_Q.
REQ-033 Reset 7 cycles into a fold -> next cycle ready=1 and value_out=0; en pulsed at fold cycle 3 is ignored and exactly one completion is seen.
REQ-034 VERIFIER_MLE_FOLD_REDUCE_EN build with vals_in[i] = `F_Q + i -> same result as vals_in[i] = i.

Source files
------------

// File: rtl/verifier_mle_fold.sv
// Multilinear-extension evaluator: folds a 2^nValBits table against tau, nParallel pairs per cycle.
// Optional build macro VERIFIER_MLE_FOLD_REDUCE_EN reduces tau/vals_in mod F_Q as they are latched.
`ifndef F_NBITS
`define F_NBITS 64
`endif
`ifndef F_Q
`define F_Q 64'h1FFF_FFFF_FFFF_FFFF
`endif

module verifier_mle_fold #(
    parameter int nValBits   = 6,
    parameter int nParBits   = 2,
    parameter int nEarlyBits = 4
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic                early,
    input  logic [`F_NBITS-1:0] tau     [nValBits],
    input  logic [`F_NBITS-1:0] vals_in [2**nValBits],
    output logic [`F_NBITS-1:0] value_out,
    output logic                ready
);
    localparam int NB        = `F_NBITS;
    localparam int nValues   = 2**nValBits;
    localparam int nParallel = 2**nParBits;
    localparam int RW        = $clog2(nValBits + 1);
    localparam int KW        = nValBits + 1;
    localparam logic [NB-1:0] Q = `F_Q;

    typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

    state_t        state, next_state;
    logic [RW-1:0] round_q;
    logic [KW-1:0] pair_base;
    logic          early_q;
    logic          ready_q;
    logic [NB-1:0] value_q;
    logic [NB-1:0] tau_q [nValBits];
    logic [NB-1:0] w     [nValues];

    logic                 start;
    logic                 last_chunk;
    logic                 last_round;
    logic [RW-1:0]        m_last;
    logic [KW-1:0]        pairs;
    logic [NB-1:0]        tau_r;
    logic [nParallel-1:0] lane_valid;
    logic [nValBits-1:0]  lane_idx [nParallel];
    logic [NB-1:0]        lane_res [nParallel];

    function automatic logic [NB-1:0] latch_word(input logic [NB-1:0] x);
`ifdef VERIFIER_MLE_FOLD_REDUCE_EN
        return x % Q;
`else
        return x;
`endif
    endfunction

    // a + t*(b - a) mod Q, every intermediate kept canonical
    function automatic logic [NB-1:0] fold_pair(input logic [NB-1:0] a,
                                                input logic [NB-1:0] b,
                                                input logic [NB-1:0] t);
        logic [NB:0]   diff;
        logic [NB-1:0] prod_r;
        logic [NB:0]   sum;
        diff = {1'b0, b} + {1'b0, Q} - {1'b0, a};
        if (diff >= {1'b0, Q}) diff = diff - {1'b0, Q};
        prod_r = NB'(({{NB{1'b0}}, t} * {{NB{1'b0}}, diff[NB-1:0]}) % {{NB{1'b0}}, Q});
        sum = {1'b0, a} + {1'b0, prod_r};
        if (sum >= {1'b0, Q}) sum = sum - {1'b0, Q};
        return sum[NB-1:0];
    endfunction

    assign start      = en && ready_q && (state != FOLD);
    assign m_last     = early_q ? RW'(nEarlyBits - 1) : RW'(nValBits - 1);
    assign pairs      = KW'(1) << (m_last - round_q);
    assign last_round = (round_q == m_last);
    assign last_chunk = (pair_base + KW'(nParallel)) >= pairs;
    assign tau_r      = tau_q[round_q];
    assign value_out  = value_q;
    assign ready      = ready_q;

    always_comb begin
        for (int j = 0; j < nParallel; j++) begin
            lane_valid[j] = (pair_base + KW'(j)) < pairs;
            lane_idx[j]   = nValBits'(pair_base + KW'(j));
            lane_res[j]   = fold_pair(w[{lane_idx[j][nValBits-2:0], 1'b0}],
                                      w[{lane_idx[j][nValBits-2:0], 1'b1}],
                                      tau_r);
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: if (start) next_state = FOLD;
            FOLD:       if (last_chunk && last_round) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // The first DONE cycle publishes w[0]; ready only rises once value_out is valid
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= IDLE;
            round_q   <= '0;
            pair_base <= '0;
            ready_q   <= 1'b1;
            value_q   <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                ready_q   <= 1'b0;
                round_q   <= '0;
                pair_base <= '0;
            end else if (state == FOLD) begin
                if (last_chunk) begin
                    pair_base <= '0;
                    round_q   <= last_round ? '0 : round_q + RW'(1);
                end else begin
                    pair_base <= pair_base + KW'(nParallel);
                end
            end else if (state == DONE && !ready_q) begin
                ready_q <= 1'b1;
                value_q <= w[0];
            end
        end
    end

    // In-place fold is hazard-free: ascending k never overwrites a word still to be read
    always_ff @(posedge clk) begin
        if (start) begin
            early_q <= early;
            for (int i = 0; i < nValBits; i++) tau_q[i] <= latch_word(tau[i]);
            for (int i = 0; i < nValues; i++)  w[i]     <= latch_word(vals_in[i]);
        end else if (state == FOLD) begin
            for (int j = 0; j < nParallel; j++) begin
                if (lane_valid[j]) w[lane_idx[j]] <= lane_res[j];
            end
        end
    end

endmodule

// File: tb/tb_verifier_mle_fold.sv
// Self-checking bench for verifier_mle_fold: chi-table reference model with an expected-value queue.
`ifndef F_NBITS
`define F_NBITS 64
`endif
`ifndef F_Q
`define F_Q 64'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_verifier_mle_fold;
    localparam int NB         = `F_NBITS;
    localparam int NV         = 6;
    localparam int NE         = 4;
    localparam int NVALS      = 2**NV;
    localparam int TIMEOUT    = 200;
    localparam int LAT_FULL   = 18;
    localparam int LAT_EARLY  = 6;
    localparam logic [NB-1:0] Q = `F_Q;

    logic          clk = 1'b0;
    logic          rstb;
    logic          en;
    logic          early;
    logic [NB-1:0] tau     [NV];
    logic [NB-1:0] vals_in [NVALS];
    logic [NB-1:0] value_out;
    logic          ready;

    logic [NB-1:0] exp_q [$];
    logic [NB-1:0] last_exp;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    verifier_mle_fold dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .early     (early),
        .tau       (tau),
        .vals_in   (vals_in),
        .value_out (value_out),
        .ready     (ready)
    );

    function automatic logic [NB-1:0] rand_fe();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        return NB'(x % 64'(Q));
    endfunction

    function automatic logic [NB-1:0] addmod(input logic [NB-1:0] a, input logic [NB-1:0] b);
        logic [NB:0] s;
        s = {1'b0, a} + {1'b0, b};
        return NB'(s % {1'b0, Q});
    endfunction

    function automatic logic [NB-1:0] mulmod(input logic [NB-1:0] a, input logic [NB-1:0] b);
        return NB'(({{NB{1'b0}}, a} * {{NB{1'b0}}, b}) % {{NB{1'b0}}, Q});
    endfunction

    function automatic logic [NB-1:0] submod(input logic [NB-1:0] a, input logic [NB-1:0] b);
        return addmod(a, Q - b);
    endfunction

    // Sum over i of chi_i(tau) * vals_in[i], chi built bit by bit from tau
    function automatic logic [NB-1:0] model(input int m);
        logic [NB-1:0] acc;
        logic [NB-1:0] chi;
        acc = '0;
        for (int i = 0; i < (1 << m); i++) begin
            chi = NB'(1);
            for (int b = 0; b < m; b++)
                chi = mulmod(chi, (((i >> b) & 1) != 0) ? tau[b] : submod(NB'(1), tau[b]));
            acc = addmod(acc, mulmod(chi, vals_in[i]));
        end
        return acc;
    endfunction

    task automatic randomize_inputs();
        for (int b = 0; b < NV; b++) tau[b] = rand_fe();
        for (int i = 0; i < NVALS; i++) vals_in[i] = rand_fe();
    endtask

    task automatic start_and_wait(input logic early_v, output logic rdy0,
                                  output int lat, output logic [NB-1:0] val);
        early = early_v;
        en    = 1'b1;
        @(posedge clk); #1;
        en   = 1'b0;
        rdy0 = ready;
        lat  = -1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = c;
                break;
            end
        end
        val = value_out;
    endtask

    task automatic test_reset();
        rstb  = 1'b0;
        en    = 1'b0;
        early = 1'b0;
        for (int b = 0; b < NV; b++) tau[b] = '0;
        for (int i = 0; i < NVALS; i++) vals_in[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %0b expected 1", ready);
        end
        n_checks++;
        if (value_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_value: got %0h expected 0", value_out);
        end
        rstb = 1'b1;
    endtask

    task automatic test_constant_table();
        logic          rdy0;
        int            lat;
        logic [NB-1:0] got, exp_v;
        for (int b = 0; b < NV; b++) tau[b] = rand_fe();
        for (int i = 0; i < NVALS; i++) vals_in[i] = NB'(5);
        exp_q.push_back(NB'(5));
        start_and_wait(1'b0, rdy0, lat, got);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdy0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL const_busy: ready got %0b expected 0", rdy0);
        end
        n_checks++;
        if (lat != LAT_FULL) begin
            n_fail++;
            $display("[TB] FAIL const_latency: got %0d expected %0d", lat, LAT_FULL);
        end
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL const_value: got %0h expected %0h", got, exp_v);
        end
        last_exp = exp_v;
    endtask

    task automatic test_corners();
        logic          rdy0;
        int            lat;
        logic [NB-1:0] got, exp_v;
        int            pick [3];
        pick[0] = 0;
        pick[1] = 63;
        pick[2] = 1;
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            for (int b = 0; b < NV; b++) tau[b] = (c == 1) ? NB'(1) : '0;
            if (c == 2) tau[0] = NB'(1);
            exp_q.push_back(vals_in[pick[c]]);
            start_and_wait(1'b0, rdy0, lat, got);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (lat != LAT_FULL) begin
                n_fail++;
                $display("[TB] FAIL corner%0d_latency: got %0d expected %0d", c, lat, LAT_FULL);
            end
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL corner%0d_value: got %0h expected %0h", c, got, exp_v);
            end
            last_exp = exp_v;
        end
    endtask

    task automatic test_early();
        logic          rdy0;
        int            lat;
        logic [NB-1:0] got, exp_v;
        randomize_inputs();
        for (int b = 0; b < NV; b++) tau[b] = NB'(1);
        exp_q.push_back(vals_in[15]);
        start_and_wait(1'b1, rdy0, lat, got);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdy0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL early_busy: ready got %0b expected 0", rdy0);
        end
        n_checks++;
        if (lat != LAT_EARLY) begin
            n_fail++;
            $display("[TB] FAIL early_latency: got %0d expected %0d", lat, LAT_EARLY);
        end
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL early_value: got %0h expected %0h", got, exp_v);
        end

        // Words outside the active 16-entry table and tau[4..5] must not matter
        exp_q.push_back(vals_in[15]);
        for (int i = 16; i < NVALS; i++) vals_in[i] = rand_fe();
        tau[4] = rand_fe();
        tau[5] = rand_fe();
        start_and_wait(1'b1, rdy0, lat, got);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL early_unused_inputs: got %0h expected %0h", got, exp_v);
        end

        randomize_inputs();
        exp_q.push_back(model(NE));
        start_and_wait(1'b1, rdy0, lat, got);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL early_random: got %0h expected %0h", got, exp_v);
        end
        last_exp = exp_v;
    endtask

    task automatic test_back_to_back();
        logic          rdy0;
        int            lat;
        logic          e;
        logic [NB-1:0] got, exp_v;
        for (int run = 0; run < 8; run++) begin
            e = run[0];
            randomize_inputs();
            exp_q.push_back(model(e ? NE : NV));
            start_and_wait(e, rdy0, lat, got);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (lat != (e ? LAT_EARLY : LAT_FULL)) begin
                n_fail++;
                $display("[TB] FAIL b2b%0d_latency: got %0d expected %0d", run, lat,
                         e ? LAT_EARLY : LAT_FULL);
            end
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL b2b%0d_value: got %0h expected %0h", run, got, exp_v);
            end
            last_exp = exp_v;
        end
    endtask

    task automatic test_ignore_en();
        logic [NB-1:0] got, exp_v;
        int            completions, first_lat;
        logic          prev_rdy;
        randomize_inputs();
        early = 1'b0;
        exp_q.push_back(model(NV));
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        n_checks++;
        if (value_out !== last_exp) begin
            n_fail++;
            $display("[TB] FAIL hold_value: got %0h expected %0h", value_out, last_exp);
        end
        completions = 0;
        first_lat   = -1;
        got         = '0;
        prev_rdy    = ready;
        for (int c = 4; c <= 60; c++) begin
            @(posedge clk); #1;
            if (ready && !prev_rdy) begin
                completions++;
                if (first_lat < 0) begin
                    first_lat = c;
                    got       = value_out;
                end
            end
            prev_rdy = ready;
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (completions != 1) begin
            n_fail++;
            $display("[TB] FAIL ignore_en_completions: got %0d expected 1", completions);
        end
        n_checks++;
        if (first_lat != LAT_FULL) begin
            n_fail++;
            $display("[TB] FAIL ignore_en_latency: got %0d expected %0d", first_lat, LAT_FULL);
        end
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL ignore_en_value: got %0h expected %0h", got, exp_v);
        end
        last_exp = exp_v;
    endtask

    task automatic test_reset_midfold();
        logic          rdy0;
        int            lat, bad;
        logic [NB-1:0] got, exp_v;
        randomize_inputs();
        early = 1'b0;
        en    = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rstb = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_ready: got %0b expected 1", ready);
        end
        n_checks++;
        if (value_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset_value: got %0h expected 0", value_out);
        end
        rstb = 1'b1;
        bad  = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (ready !== 1'b1 || value_out !== '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_quiet: got %0d disturbed cycles expected 0", bad);
        end

        randomize_inputs();
        exp_q.push_back(model(NV));
        start_and_wait(1'b0, rdy0, lat, got);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (lat != LAT_FULL) begin
            n_fail++;
            $display("[TB] FAIL post_reset_latency: got %0d expected %0d", lat, LAT_FULL);
        end
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL post_reset_value: got %0h expected %0h", got, exp_v);
        end
        last_exp = exp_v;
    endtask

`ifdef VERIFIER_MLE_FOLD_REDUCE_EN
    task automatic test_reduce();
        logic          rdy0;
        int            lat;
        logic [NB-1:0] got, exp_v;
        for (int b = 0; b < NV; b++) tau[b] = rand_fe();
        for (int i = 0; i < NVALS; i++) vals_in[i] = NB'(i);
        exp_q.push_back(model(NV));
        for (int i = 0; i < NVALS; i++) vals_in[i] = Q + NB'(i);
        start_and_wait(1'b0, rdy0, lat, got);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reduce_value: got %0h expected %0h", got, exp_v);
        end
        last_exp = exp_v;
    endtask
`endif

    initial begin
        void'($urandom(3));
        last_exp = '0;
        test_reset();
        test_constant_table();
        test_corners();
        test_early();
        test_back_to_back();
        test_ignore_en();
        test_reset_midfold();
`ifdef VERIFIER_MLE_FOLD_REDUCE_EN
        test_reduce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
